// File: rtl/station_pkg.sv
// Shared opcodes, FSM state encoding and command/ID field layouts for station_cntrl.
// Both input bytes split into a 2-bit tag and a 6-bit station number.
package station_pkg;

  localparam int OP_W = 2;
  localparam int STN_W = 6;
  localparam int BYTE_W = OP_W + STN_W;

  localparam logic [OP_W-1:0] OP_STOP = 2'b00;
  localparam logic [OP_W-1:0] OP_GO = 2'b01;

  typedef enum logic {
    IDLE,
    TRANSIT
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [STN_W-1:0] dest;
  } cmd_t;

  typedef struct packed {
    logic [OP_W-1:0]  tag;
    logic [STN_W-1:0] stn;
  } id_t;

endpackage

// File: rtl/transit_tmr.sv
// Transit watchdog: counts enabled cycles since the last clear; expired is combinational from the count.
// Latency: expired asserts in the cycle the count sits at TMO_CYC-1 or beyond; no backpressure.
module transit_tmr #(
  parameter int TMO_W = 24,
  parameter logic [TMO_W-1:0] TMO_CYC = 24'hFF_FFFF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  // >= so a route kept alive by a terminal-cycle ID mismatch still times out next cycle
  assign expired = (cnt >= (TMO_CYC - TMO_W'(1)));

endmodule

// File: rtl/station_cntrl.sv
// Station route controller: UART GO/STOP commands vs barcode IDs; clr_* consume inputs in the service cycle.
// in_transit updates one cycle after service; command wins over ID. Optional watchdog: TRANSIT_TIMEOUT_EN.
module station_cntrl
  import station_pkg::*;
#(
  parameter int TMO_W = 24,
  parameter logic [TMO_W-1:0] TMO_CYC = 24'hFF_FFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd,
  input  logic       cmd_rdy,
  output logic       clr_cmd_rdy,
  input  logic [7:0] ID,
  input  logic       ID_vld,
  output logic       clr_ID_vld,
  input  logic       OK2Move,
  output logic       in_transit,
  output logic       go,
  output logic       buzz_en,
  output logic       tmo
);

  state_t           state, nxt_state;
  logic [STN_W-1:0] dest_id, nxt_dest_id;
  logic             go_acc;
  logic             tmo_set;
  logic             expired;
  cmd_t             cmd_f;
  id_t              id_f;

  assign cmd_f = cmd_t'(cmd);
  assign id_f  = id_t'(ID);

  assign in_transit = (state == TRANSIT);
  assign go         = in_transit & OK2Move;
  assign buzz_en    = in_transit & ~OK2Move;

`ifdef TRANSIT_TIMEOUT_EN
  logic tmo_q;

  transit_tmr #(
    .TMO_W  (TMO_W),
    .TMO_CYC(TMO_CYC)
  ) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .en     (go),
    .clr    (go_acc),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= 1'b0;
    end else if (go_acc) begin
      tmo_q <= 1'b0;
    end else if (tmo_set) begin
      tmo_q <= 1'b1;
    end
  end

  assign tmo = tmo_q;
`else
  logic unused_cfg;

  assign expired    = 1'b0;
  assign tmo        = 1'b0;
  assign unused_cfg = ^{TMO_CYC, go_acc, tmo_set};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dest_id <= '0;
    end else begin
      state   <= nxt_state;
      dest_id <= nxt_dest_id;
    end
  end

  always_comb begin
    nxt_state   = state;
    nxt_dest_id = dest_id;
    clr_cmd_rdy = 1'b0;
    clr_ID_vld  = 1'b0;
    go_acc      = 1'b0;
    tmo_set     = 1'b0;
    if (!rst) begin
      if (cmd_rdy) begin
        // ID_vld is left pending so it is judged against the updated destination
        clr_cmd_rdy = 1'b1;
        if (cmd_f.op == OP_GO) begin
          nxt_dest_id = cmd_f.dest;
          nxt_state   = TRANSIT;
          go_acc      = 1'b1;
        end else if (cmd_f.op == OP_STOP) begin
          nxt_state = IDLE;
        end
      end else if (ID_vld) begin
        clr_ID_vld = 1'b1;
        if (state == TRANSIT && id_f.tag == 2'b00 && id_f.stn == dest_id) begin
          nxt_state = IDLE;
        end
      end else if (state == TRANSIT && expired) begin
        nxt_state = IDLE;
        tmo_set   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_station_cntrl.sv
// Directed bench for station_cntrl with a service scoreboard; the timeout scenario runs when TRANSIT_TIMEOUT_EN is defined.
module tb_station_cntrl;

  logic       clk;
  logic       rst;
  logic [7:0] cmd;
  logic       cmd_rdy;
  logic       clr_cmd_rdy;
  logic [7:0] ID;
  logic       ID_vld;
  logic       clr_ID_vld;
  logic       OK2Move;
  logic       in_transit;
  logic       go;
  logic       buzz_en;
  logic       tmo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string tag;
    bit    is_cmd;
    bit    exp_transit;
  } rec_t;

  rec_t     sb[$];
  bit       mdl_transit;
  bit [5:0] mdl_dest;

  station_cntrl #(
    .TMO_W  (24),
    .TMO_CYC(24'd16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .ID         (ID),
    .ID_vld     (ID_vld),
    .clr_ID_vld (clr_ID_vld),
    .OK2Move    (OK2Move),
    .in_transit (in_transit),
    .go         (go),
    .buzz_en    (buzz_en),
    .tmo        (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input string tag, input logic [7:0] c);
    cmd     = c;
    cmd_rdy = 1'b1;
    if (c[7:6] == 2'b01) begin
      mdl_transit = 1'b1;
      mdl_dest    = c[5:0];
    end else if (c[7:6] == 2'b00) begin
      mdl_transit = 1'b0;
    end
    sb.push_back('{tag, 1'b1, mdl_transit});
  endtask

  task automatic send_id(input string tag, input logic [7:0] i);
    ID     = i;
    ID_vld = 1'b1;
    if (mdl_transit && i[7:6] == 2'b00 && i[5:0] == mdl_dest) mdl_transit = 1'b0;
    sb.push_back('{tag, 1'b0, mdl_transit});
  endtask

  // Called at a negedge; waits for the oldest scoreboard item to be consumed, then checks the outcome.
  task automatic service();
    rec_t rec;
    bit   got;
    rec = sb.pop_front();
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      #1;
      if (rec.is_cmd ? clr_cmd_rdy : clr_ID_vld) begin
        got = 1'b1;
        chk({rec.tag, "_other_clr"}, rec.is_cmd ? clr_ID_vld : clr_cmd_rdy, 8'h0);
      end
      @(posedge clk);
      #1;
      if (got) begin
        if (rec.is_cmd) cmd_rdy = 1'b0;
        else ID_vld = 1'b0;
      end
      @(negedge clk);
    end
    chk({rec.tag, "_consumed"}, got, 8'h1);
    chk({rec.tag, "_single_pulse"}, rec.is_cmd ? clr_cmd_rdy : clr_ID_vld, 8'h0);
    chk({rec.tag, "_in_transit"}, in_transit, rec.exp_transit);
  endtask

  initial begin
    rst         = 1'b1;
    cmd         = 8'h42;
    cmd_rdy     = 1'b1;
    ID          = 8'h00;
    ID_vld      = 1'b0;
    OK2Move     = 1'b1;
    mdl_transit = 1'b0;
    mdl_dest    = 6'h00;
    repeat (2) @(negedge clk);
    chk("rst_clr_cmd", clr_cmd_rdy, 8'h0);
    chk("rst_in_transit", in_transit, 8'h0);
    chk("rst_go", go, 8'h0);
    chk("rst_buzz", buzz_en, 8'h0);
    chk("rst_tmo", tmo, 8'h0);

    // pending GO is serviced right after reset release
    rst = 1'b0;
    send_cmd("go42", 8'h42);
    service();
    chk("go42_go", go, 8'h1);
    chk("go42_buzz", buzz_en, 8'h0);

    send_id("id01", 8'h01);
    service();
    send_id("id02", 8'h02);
    service();
    chk("id02_go", go, 8'h0);

    send_cmd("go42b", 8'h42);
    service();
    OK2Move = 1'b0;
    #1;
    chk("blocked_go", go, 8'h0);
    chk("blocked_buzz", buzz_en, 8'h1);
    @(negedge clk);
    chk("blocked_transit", in_transit, 8'h1);
    OK2Move = 1'b1;
    #1;
    chk("clear_go", go, 8'h1);
    chk("clear_buzz", buzz_en, 8'h0);
    @(negedge clk);

    send_cmd("stop", 8'h00);
    service();
    send_cmd("ign_c5", 8'hC5);
    service();
    send_id("idle_id", 8'h02);
    service();

    // command and ID together: command first, ID then judged against new dest 3
    send_cmd("go42c", 8'h42);
    service();
    send_cmd("go43", 8'h43);
    send_id("id02_vs3", 8'h02);
    service();
    service();
    send_id("id43tag", 8'h43);
    service();
    send_id("id03", 8'h03);
    service();

    send_cmd("go45", 8'h45);
    service();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mdl_transit = 1'b0;
    mdl_dest    = 6'h00;
    #1;
    chk("midrst_transit", in_transit, 8'h0);
    chk("midrst_tmo", tmo, 8'h0);
    chk("midrst_go", go, 8'h0);
    @(negedge clk);

`ifdef TRANSIT_TIMEOUT_EN
    send_cmd("tmo_go", 8'h41);
    service();
    repeat (15) @(negedge clk);
    chk("tmo_before", in_transit, 8'h1);
    @(negedge clk);
    chk("tmo_after_transit", in_transit, 8'h0);
    chk("tmo_flag", tmo, 8'h1);
    mdl_transit = 1'b0;
    send_cmd("tmo_regoo", 8'h41);
    service();
    chk("tmo_cleared", tmo, 8'h0);
    OK2Move = 1'b0;
    repeat (30) @(negedge clk);
    chk("tmo_hold_transit", in_transit, 8'h1);
    OK2Move = 1'b1;
    repeat (15) @(negedge clk);
    chk("tmo_hold_before", in_transit, 8'h1);
    @(negedge clk);
    chk("tmo_hold_after", in_transit, 8'h0);
    chk("tmo_hold_flag", tmo, 8'h1);
    mdl_transit = 1'b0;
`else
    send_cmd("notmo_go", 8'h41);
    service();
    repeat (40) @(negedge clk);
    chk("notmo_transit", in_transit, 8'h1);
    chk("notmo_flag", tmo, 8'h0);
    send_cmd("notmo_stop", 8'h00);
    service();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/station_cntrl.md
STATION_CNTRL -- requirements
Module: station_cntrl

Interface
REQ-001 The block SHALL have parameter TMO_W, default 24, giving the transit-timeout counter width.
REQ-002 The block SHALL have parameter TMO_CYC, default 24'hFF_FFFF, giving the transit-timeout limit in cycles.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port cmd, input, 8 bits: UART command byte; [7:6] is the opcode, [5:0] is the destination station ID.
REQ-006 The block SHALL have port cmd_rdy, input, 1 bit: cmd is valid; held high until cleared.
REQ-007 The block SHALL have port clr_cmd_rdy, output, 1 bit: consumes cmd.
REQ-008 The block SHALL have port ID, input, 8 bits: barcode station ID byte.
REQ-009 The block SHALL have port ID_vld, input, 1 bit: ID is valid; held high until cleared.
REQ-010 The block SHALL have port clr_ID_vld, output, 1 bit: consumes ID.
REQ-011 The block SHALL have port OK2Move, input, 1 bit: proximity sensor reports the path is clear.
REQ-012 The block SHALL have port in_transit, output, 1 bit: a route is active.
REQ-013 The block SHALL have port go, output, 1 bit: motor enable for the PID/motor path.
REQ-014 The block SHALL have port buzz_en, output, 1 bit: obstacle alarm enable.
REQ-015 The block SHALL have port tmo, output, 1 bit: sticky flag meaning the last route was aborted by timeout.

Function
REQ-016 Opcodes SHALL be: 2'b00 = STOP, 2'b01 = GO(dest = cmd[5:0]); 2'b10 and 2'b11 are ignored but still consumed.
REQ-017 The FSM SHALL have exactly two states, IDLE and TRANSIT; in_transit SHALL be 1 iff the state is TRANSIT.
REQ-018 clr_cmd_rdy and clr_ID_vld SHALL be combinational, asserted in the same cycle the item is serviced, and never asserted for an input that is low.
REQ-019 In IDLE with cmd_rdy and GO: latch dest_ID <= cmd[5:0], clear the counter, clear tmo, and enter TRANSIT at the next edge.
REQ-020 In IDLE, STOP or an ignored opcode SHALL be consumed only; any ID_vld SHALL be consumed and discarded.
REQ-021 In TRANSIT with cmd_rdy and STOP: enter IDLE.
REQ-022 In TRANSIT with cmd_rdy and GO: reload dest_ID, restart the counter, and stay in TRANSIT.
REQ-023 In TRANSIT with ID_vld and no cmd_rdy: consume ID; if ID[7:6]==2'b00 and ID[5:0]==dest_ID, enter IDLE; otherwise stay in TRANSIT.
REQ-024 When cmd_rdy and ID_vld are high in the same cycle, the command SHALL be serviced first; ID_vld SHALL stay pending and be serviced the next cycle against the updated dest_ID.
REQ-025 go SHALL equal in_transit & OK2Move, and buzz_en SHALL equal in_transit & ~OK2Move; both are combinational outputs.
REQ-026 Timing SHALL be as follows: a matching ID arrives, in_transit falls 1 cycle later, and go falls in that same cycle.

Reset
REQ-027 rst SHALL force state IDLE, dest_ID=6'h00, counter=0, and tmo=0; consequently in_transit, go, and buzz_en are 0.
REQ-028 The clr_* outputs SHALL be held 0 while rst is high; pending inputs SHALL be serviced starting from the first cycle after rst deasserts.
REQ-029 Reset asserted mid-route SHALL abort the route without setting tmo.

Configuration
REQ-030 With macro TRANSIT_TIMEOUT_EN defined, a TMO_W-bit counter SHALL increment each cycle go=1 and hold while go=0.
REQ-031 With TRANSIT_TIMEOUT_EN defined, when the count reaches TMO_CYC-1 the block SHALL enter IDLE and set tmo=1; tmo clears on the next accepted GO or on rst.
REQ-032 With TRANSIT_TIMEOUT_EN defined, a cmd_rdy or ID_vld serviced in the terminal-count cycle SHALL take precedence over the timeout.
REQ-033 Without TRANSIT_TIMEOUT_EN, no counter SHALL be built, tmo SHALL be tied to 0, and TMO_W and TMO_CYC are unused.

Structure
REQ-034 Package station_pkg SHALL hold the opcode localparams (OP_STOP, OP_GO), the state enum (IDLE, TRANSIT), and the ID field widths.
REQ-035 Sub-module transit_tmr SHALL hold the counter and comparator (inputs en, clr; output expired), instantiated only under TRANSIT_TIMEOUT_EN.

Verification
REQ-036 Scenario: from reset, cmd=8'h42 with cmd_rdy, then OK2Move=1 -> clr_cmd_rdy pulses once, in_transit=1 next cycle, and go=1.
REQ-037 Scenario: in transit to 6'h02, ID=8'h01 -> ID consumed and in_transit stays 1; then ID=8'h02 -> in_transit=0 one cycle later.
REQ-038 Scenario: in transit, OK2Move=0 -> go=0, buzz_en=1, and the counter holds; then OK2Move=1 -> go=1 and buzz_en=0.
REQ-039 Scenario: in transit, cmd=8'h00 -> IDLE; cmd=8'hC5 in IDLE -> consumed with no state change.
REQ-040 Scenario: in transit, cmd=8'h43 and ID=8'h02 in the same cycle -> cmd consumed first; next cycle ID consumed and route continues (dest is now 3).
REQ-041 Scenario: with TRANSIT_TIMEOUT_EN and TMO_CYC=16, GO and no ID -> IDLE with tmo=1 after 16 go-cycles; a fresh GO clears tmo.
